// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and frame constants for the UART transmit path
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  localparam int DATA_BITS = 8;
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: power-of-two circular byte buffer; push is ignored when full, pop when empty
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic [DATA_BITS-1:0]   din,
  input  logic                   pop,
  output logic [DATA_BITS-1:0]   dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] count_q;
  logic do_push, do_pop;
  assign full    = count_q == (AW+1)'(DEPTH);
  assign empty   = count_q == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_q];
  assign count   = count_q;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_q + AW'(do_push);
      rd_q    <= rd_q + AW'(do_pop);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  // storage needs no reset: pointers alone define which entries are live
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter fed by a valid/ready byte interface
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 868,
  parameter int DEPTH       = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   tx_valid,
  input  logic [DATA_BITS-1:0]   txdata,
  output logic                   tx_ready,
  output logic                   txd,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count
);
  localparam int BW = $clog2(CLK_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);
  tx_state_t state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [IW-1:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d, fifo_dout;
  logic txd_q, txd_d, term, load, fifo_full, fifo_empty;
  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (tx_valid),
    .din   (txdata),
    .pop   (load),
    .dout  (fifo_dout),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
  assign term = baud_q == BAUD_MAX;
  // a frame is loaded from IDLE or straight out of a finishing stop bit, so frames chain with no gap
  assign load = !fifo_empty && (state_q == IDLE || (state_q == STOP && term));
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = START;
      START:   if (term) state_d = DATA;
      DATA:    if (term && bit_q == LAST_BIT) state_d = STOP;
      STOP:    if (term) state_d = fifo_empty ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    baud_d  = (state_q == IDLE || term) ? '0 : baud_q + BW'(1);
    shreg_d = load ? fifo_dout : (state_q == DATA && term) ? shreg_q >> 1 : shreg_q;
    bit_d   = (state_q == START) ? '0 : (state_q == DATA && term) ? bit_q + IW'(1) : bit_q;
    txd_d   = load ? 1'b0
            : (state_q == START && term) ? shreg_q[0]
            : (state_q == DATA && term) ? ((bit_q == LAST_BIT) ? 1'b1 : shreg_q[1])
            : txd_q;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      txd_q   <= txd_d;
    end
  always_comb begin
    tx_ready = !fifo_full;
    busy     = (state_q != IDLE) || !fifo_empty;
    txd      = txd_q;
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of the buffered UART transmitter at 4 and 868 clocks per bit
module tb_uart_tx_fifo;
  logic clk, rstn, tx_valid, tx_valid2, tx_ready, tx_ready2, txd, txd2, busy, busy2;
  logic [7:0] txdata, txdata2, sh;
  logic [2:0] count;
  logic [4:0] count2;
  int n_tests = 0, n_fail = 0, cyc = 0, ph = 0;
  logic act = 1'b0, rec_en = 1'b0;
  logic [7:0] rx_q[$], acc_q[$];
  int starts[$];
  logic [7:0] exp_b [6] = '{8'h00, 8'hFF, 8'h55, 8'h0F, 8'hAA, 8'h77};

  uart_tx_fifo #(.CLK_PER_BIT(4), .DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .tx_valid(tx_valid), .txdata(txdata),
    .tx_ready(tx_ready), .txd(txd), .busy(busy), .count(count));
  uart_tx_fifo #(.CLK_PER_BIT(868), .DEPTH(16)) dut2 (
    .clk(clk), .rstn(rstn), .tx_valid(tx_valid2), .txdata(txdata2),
    .tx_ready(tx_ready2), .txd(txd2), .busy(busy2), .count(count2));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // serial decoder for the 4-clock instance: samples mid-bit, records frame start cycles
  always @(negedge clk) begin
    cyc++;
    if (!rstn) act = 1'b0;
    else if (!act) begin
      if (txd === 1'b0) begin
        act = 1'b1;
        ph = 0;
        starts.push_back(cyc);
      end
    end else begin
      ph++;
      if (ph % 4 == 2 && ph >= 6 && ph <= 34) sh = {txd, sh[7:1]};
      if (ph == 38) begin
        chk("stop_bit", txd, 1);
        rx_q.push_back(sh);
      end
      if (ph == 39) act = 1'b0;
    end
  end

  always @(negedge clk)
    if (rec_en && rstn && tx_valid && tx_ready) acc_q.push_back(txdata);

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] fr;
    logic [7:0] b;
    int n, bad;
    rstn = 1; tx_valid = 0; txdata = 0; tx_valid2 = 0; txdata2 = 0;
    #2 rstn = 0;
    #1;
    chk("rst_txd", txd, 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    step(2);
    rstn = 1;
    step(2);

    // single byte 0xA5 from idle
    rx_q.delete();
    tx_valid = 1; txdata = 8'hA5;
    step;
    tx_valid = 0;
    chk("a5_count", count, 1);
    chk("a5_busy", busy, 1);
    chk("a5_txd_k", txd, 1);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 40; i++) begin
      step;
      chk("a5_txd", txd, fr[i/4]);
      chk("a5_busy", busy, 1);
    end
    step;
    chk("a5_idle_busy", busy, 0);
    chk("a5_idle_count", count, 0);
    chk("a5_idle_txd", txd, 1);
    chk("a5_rx_n", rx_q.size(), 1);
    chk("a5_rx", rx_q.size() > 0 ? rx_q[0] : 8'h00, 8'hA5);

    // burst fill, full rejection, pop-while-full
    rx_q.delete(); starts.delete();
    tx_valid = 1; txdata = 8'h00; step; chk("b_cnt0", count, 1);
    txdata = 8'hFF; step; chk("b_cnt1", count, 1); chk("b_rdy1", tx_ready, 1);
    txdata = 8'h55; step; chk("b_cnt2", count, 2);
    txdata = 8'h0F; step; chk("b_cnt3", count, 3); chk("b_rdy3", tx_ready, 1);
    txdata = 8'hAA; step; chk("b_cnt4", count, 4); chk("b_rdy4", tx_ready, 0);
    txdata = 8'hEE; step(36);
    chk("full_cnt", count, 4);
    chk("full_rdy", tx_ready, 0);
    txdata = 8'h99; step;
    chk("pop_cnt", count, 3);
    chk("pop_rdy", tx_ready, 1);
    txdata = 8'h77; step;
    chk("refill_cnt", count, 4);
    tx_valid = 0;
    n = 0;
    while (busy && n < 500) begin step; n++; end
    chk("b_drain", busy, 0);
    chk("b_frames", rx_q.size(), 6);
    for (int i = 0; i < 6 && i < rx_q.size(); i++) chk("b_byte", rx_q[i], exp_b[i]);
    bad = 0;
    for (int i = 1; i < starts.size(); i++) if (starts[i] - starts[i-1] != 40) bad++;
    chk("b_starts", starts.size(), 6);
    chk("b_gap", bad, 0);

    // asynchronous reset in the middle of a data bit
    rx_q.delete();
    tx_valid = 1; txdata = 8'h3C; step;
    txdata = 8'h11; step;
    txdata = 8'h22; step;
    tx_valid = 0;
    chk("r_cnt", count, 2);
    step(6);
    chk("r_pre_txd", txd, 0);
    #2 rstn = 0;
    #1;
    chk("r_txd", txd, 1);
    chk("r_cnt0", count, 0);
    chk("r_busy", busy, 0);
    chk("r_rdy", tx_ready, 1);
    step(2);
    rstn = 1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      step;
      if (txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("r_quiet", bad, 0);
    chk("r_rx", rx_q.size(), 0);

    // full-rate instance: one 'A' frame
    tx_valid2 = 1; txdata2 = 8'h41; step;
    tx_valid2 = 0;
    n = 0;
    while (txd2 && n < 10) begin step; n++; end
    chk("l_start", txd2, 0);
    n = 0; b = 0; bad = 0;
    while (busy2 && n < 9000) begin
      step; n++;
      if (n % 868 == 434) begin
        if (n / 868 >= 1 && n / 868 <= 8) b = {txd2, b[7:1]};
        else if (txd2 !== (n / 868 == 9)) bad++;
      end
    end
    chk("l_len", n, 8680);
    chk("l_byte", b, 8'h41);
    chk("l_framing", bad, 0);

    // random traffic against the accepted-byte queue
    rx_q.delete(); acc_q.delete();
    rec_en = 1; bad = 0; n = 0;
    while (acc_q.size() < 100 && n < 20000) begin
      tx_valid = ($urandom_range(0, 1) == 1);
      txdata = 8'($urandom);
      step; n++;
      if (count > 4 || (count != 0 && !busy) || (act && !busy)) bad++;
    end
    tx_valid = 0;
    n = 0;
    while (busy && n < 1000) begin step; n++; end
    step(2);
    chk("q_bound", bad, 0);
    chk("q_drain", busy, 0);
    chk("q_n", rx_q.size(), acc_q.size());
    bad = 0;
    for (int i = 0; i < rx_q.size() && i < acc_q.size(); i++) if (rx_q[i] !== acc_q[i]) bad++;
    chk("q_data", bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
